// File: rtl/motor_drive_sequencer_if.sv
// Command bus between the supervisory controller and the motor drive sequencer.
// master = side that issues duty/direction requests, slave = the sequencer.
interface motor_drive_sequencer_if #(
    parameter int K_PWMRES = 10,
    parameter int K_DWELLW = 16
);
    logic                i_enable;
    logic [K_PWMRES-1:0] i_target;
    logic                i_target_rev;
    logic                i_target_valid;
    logic                i_ramp_tick;
    logic                i_fault;
    logic [K_PWMRES-1:0] i_param_ramp_step;
    logic [K_PWMRES-1:0] i_param_pwm_max;
    logic [K_DWELLW-1:0] i_param_brake_dwell;
    logic [K_PWMRES-1:0] o_pwm_command;
    logic                o_reverse;
    logic                o_brake;
    logic [2:0]          o_state;
    logic                o_busy;

    modport master (
        output i_enable, i_target, i_target_rev, i_target_valid, i_ramp_tick,
               i_fault, i_param_ramp_step, i_param_pwm_max, i_param_brake_dwell,
        input  o_pwm_command, o_reverse, o_brake, o_state, o_busy
    );

    modport slave (
        input  i_enable, i_target, i_target_rev, i_target_valid, i_ramp_tick,
               i_fault, i_param_ramp_step, i_param_pwm_max, i_param_brake_dwell,
        output o_pwm_command, o_reverse, o_brake, o_state, o_busy
    );
endinterface

// File: rtl/motor_drive_sequencer.sv
// Motor drive sequencer: slew-limited duty command, brake-dwell direction
// reversal and fault braking. All outputs come straight from flops.
module motor_drive_sequencer #(
    parameter int K_PWMRES = 10,
    parameter int K_DWELLW = 16
) (
    input logic                    i_clk,
    input logic                    i_rst,
    motor_drive_sequencer_if.slave bus
);
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RAMP  = 3'd1,
        ST_HOLD  = 3'd2,
        ST_DWELL = 3'd3,
        ST_FAULT = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic [K_PWMRES-1:0] cmd_q, cmd_d;
    logic [K_PWMRES-1:0] tgt_q, tgt_d;
    logic                tgt_rev_q, tgt_rev_d;
    logic                rev_q, rev_d;
    logic                brake_q, brake_d;
    logic                busy_q, busy_d;
    logic [K_DWELLW-1:0] dwell_q, dwell_d;

    logic [K_PWMRES-1:0] step;
    logic [K_PWMRES-1:0] eff;
    logic [K_PWMRES-1:0] slew;
    logic [K_PWMRES:0]   sum_up;
    logic [K_PWMRES-1:0] diff_dn;
    logic                rev_request;
    logic                swap_wanted;

    // Effective goal and one slew step toward it (extra bit on the way up, no wrap).
    always_comb begin
        step        = (bus.i_param_ramp_step == '0) ? K_PWMRES'(1) : bus.i_param_ramp_step;
        rev_request = (tgt_rev_q != rev_q);
        swap_wanted = bus.i_enable && (tgt_q != '0) && rev_request;
        eff         = (!bus.i_enable || rev_request) ? '0 : tgt_q;
        sum_up      = {1'b0, cmd_q} + {1'b0, step};
        diff_dn     = cmd_q - eff;
        slew        = cmd_q;
        if (cmd_q < eff) begin
            slew = (sum_up > {1'b0, eff}) ? eff : sum_up[K_PWMRES-1:0];
        end else if (cmd_q > eff) begin
            slew = (diff_dn <= step) ? eff : (cmd_q - step);
        end
    end

    // Next-state, target latch, dwell counter and registered output values.
    always_comb begin
        state_d   = state_q;
        cmd_d     = cmd_q;
        rev_d     = rev_q;
        dwell_d   = dwell_q;
        tgt_d     = tgt_q;
        tgt_rev_d = tgt_rev_q;

        // Clamp happens only here, so a later ceiling change leaves tgt alone.
        if (bus.i_target_valid) begin
            tgt_d     = (bus.i_target > bus.i_param_pwm_max) ? bus.i_param_pwm_max : bus.i_target;
            tgt_rev_d = bus.i_target_rev;
        end

        if (bus.i_fault) begin
            state_d = ST_FAULT;
            cmd_d   = '0;
            dwell_d = '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    cmd_d = '0;
                    if (swap_wanted) begin
                        state_d = ST_DWELL;
                        dwell_d = '0;
                    end else if (eff != '0) begin
                        state_d = ST_RAMP;
                    end
                end
                ST_RAMP: begin
                    if (cmd_q == eff) begin
                        if (swap_wanted) begin
                            state_d = ST_DWELL;
                            dwell_d = '0;
                        end else if (eff == '0) begin
                            state_d = ST_IDLE;
                        end else begin
                            state_d = ST_HOLD;
                        end
                    end else if (bus.i_ramp_tick) begin
                        cmd_d = slew;
                    end
                end
                ST_HOLD: begin
                    if (eff != cmd_q) begin
                        state_d = ST_RAMP;
                    end
                end
                ST_DWELL: begin
                    cmd_d = '0;
                    // Abandoned reversal: leave direction untouched.
                    if (!bus.i_enable || !rev_request) begin
                        state_d = ST_IDLE;
                    end else if (dwell_q >= bus.i_param_brake_dwell) begin
                        rev_d   = tgt_rev_q;
                        dwell_d = '0;
                        state_d = ST_RAMP;
                    end else if (bus.i_ramp_tick) begin
                        dwell_d = dwell_q + K_DWELLW'(1);
                    end
                end
                ST_FAULT: begin
                    // i_fault is low here: release to IDLE and forget the request.
                    cmd_d   = '0;
                    tgt_d   = '0;
                    state_d = ST_IDLE;
                end
                default: begin
                    cmd_d   = '0;
                    state_d = ST_IDLE;
                end
            endcase
        end

        brake_d = (state_d == ST_DWELL) || (state_d == ST_FAULT);
        busy_d  = (state_d == ST_RAMP) || (state_d == ST_DWELL);
    end

    // State and output registers, cleared immediately on reset.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q   <= ST_IDLE;
            cmd_q     <= '0;
            tgt_q     <= '0;
            tgt_rev_q <= 1'b0;
            rev_q     <= 1'b0;
            brake_q   <= 1'b0;
            busy_q    <= 1'b0;
            dwell_q   <= '0;
        end else begin
            state_q   <= state_d;
            cmd_q     <= cmd_d;
            tgt_q     <= tgt_d;
            tgt_rev_q <= tgt_rev_d;
            rev_q     <= rev_d;
            brake_q   <= brake_d;
            busy_q    <= busy_d;
            dwell_q   <= dwell_d;
        end
    end

    assign bus.o_pwm_command = cmd_q;
    assign bus.o_reverse     = rev_q;
    assign bus.o_brake       = brake_q;
    assign bus.o_state       = state_q;
    assign bus.o_busy        = busy_q;
endmodule
